uart_rx: RTL

Asynchronous serial receiver, 8N1, LSB first, idle-high line. Consumes the serial stream produced by the team's UART transmitter (or an external host) on the `rx` pin. Delivers each received byte to downstream logic through a one-entry valid/ready holding register, and flags framing errors and overruns. The bit period is derived from a fixed clock frequency and baud rate, with no fractional correction.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery port of the UART receiver: one-entry valid/ready holding register plus error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; flops reset to the idle-high level.
module uart_rx_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[DEPTH-2:0], d};
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, delivering bytes through a one-entry valid/ready register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote over the last three synchronized samples.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  logic                 rx_s;
  logic                 rx_prev;
  logic                 bit_val;
  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 at_half;
  logic                 at_bit;

  uart_rx_sync #(.DEPTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[1] holds rx_s from two cycles ago, hist[0] from one cycle ago.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign at_half = (cnt == CNT_W'(HALF_BIT - 1));
  assign at_bit  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Assembly register carries no reset: it is only read after a full frame rewrites it.
  always_ff @(posedge clk) begin
    if (state == DATA && at_bit) begin
      shift[bit_idx] <= bit_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      cnt           <= cnt + 1'b1;
      if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (at_half) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= bit_val ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_bit) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (at_bit) begin
            cnt <= '0;
            if (bit_val) begin
              state <= IDLE;
              // A consumer handshake in the delivery cycle frees the slot for the new byte.
              if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shift;
                bus.rx_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
            end else begin
              bus.frame_err <= 1'b1;
              state         <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
